// File: rtl/acc_unit_if.sv
// Bus between the accumulator unit and its neighbours: command handshake, ALU link and status flags.
interface acc_unit_if #(
  parameter int W = 4
);
  localparam int AW = $clog2(W) + 1;

  logic          cmd_valid;
  logic [3:0]    cmd;
  logic [AW-1:0] cmd_amt;
  logic [W-1:0]  alu_result;
  logic          alu_co;
  logic          alu_ovf;
  logic [2:0]    alu_op;
  logic [W-1:0]  ac;
  logic          e;
  logic          ovf;
  logic          z;
  logic          n;
  logic          busy;
  logic          done;

  modport master (
    output cmd_valid, cmd, cmd_amt, alu_result, alu_co, alu_ovf,
    input  alu_op, ac, e, ovf, z, n, busy, done
  );

  modport slave (
    input  cmd_valid, cmd, cmd_amt, alu_result, alu_co, alu_ovf,
    output alu_op, ac, e, ovf, z, n, busy, done
  );
endinterface

// File: rtl/acc_unit.sv
// Accumulator unit: AC, E and overflow registers behind the ALU, with single-cycle commands.
// Define ACC_UNIT_MULTISHIFT_EN to add the CIR_N/CIL_N multi-cycle circulate (SHIFT state, counter, busy).
module acc_unit #(
  parameter int W = 4
) (
  input logic       clk,
  input logic       reset,
  acc_unit_if.slave bus
);
  localparam int AW = $clog2(W) + 1;

`ifdef ACC_UNIT_MULTISHIFT_EN
  localparam bit MS_EN = 1'b1;
`else
  localparam bit MS_EN = 1'b0;
`endif

  localparam logic [3:0] C_NOP  = 4'd0;
  localparam logic [3:0] C_ADD  = 4'd1;
  localparam logic [3:0] C_AND  = 4'd2;
  localparam logic [3:0] C_LDA  = 4'd3;
  localparam logic [3:0] C_CMA  = 4'd4;
  localparam logic [3:0] C_CIR  = 4'd5;
  localparam logic [3:0] C_CIL  = 4'd6;
  localparam logic [3:0] C_CLA  = 4'd7;
  localparam logic [3:0] C_CLE  = 4'd8;
  localparam logic [3:0] C_CME  = 4'd9;
  localparam logic [3:0] C_INC  = 4'd10;
  localparam logic [3:0] C_CIRN = 4'd11;
  localparam logic [3:0] C_CILN = 4'd12;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_TRAN = 3'd2;
  localparam logic [2:0] OP_COMP = 3'd3;
  localparam logic [2:0] OP_SHR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;

  logic [W-1:0] ac_q, ac_d;
  logic         e_q, e_d;
  logic         ovf_q, ovf_d;
  logic         done_q, done_d;
  logic         shifting;
  logic         shift_last;
  logic         shift_left;
  logic [2:0]   alu_op;

`ifdef ACC_UNIT_MULTISHIFT_EN
  // state | meaning
  // IDLE  | single-cycle commands accepted; CIR_N/CIL_N with nonzero count enters SHIFT
  // SHIFT | one ALU shift per edge until cnt reaches 1; commands ignored
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_d;
  logic [AW-1:0] cnt, cnt_d;
  logic          dir_left, dir_left_d;
  logic          start_shift;

  assign start_shift = bus.cmd_valid && (state == IDLE) &&
                       ((bus.cmd == C_CIRN) || (bus.cmd == C_CILN)) &&
                       (bus.cmd_amt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      dir_left <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      dir_left <= dir_left_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    dir_left_d = dir_left;
    case (state)
      IDLE: begin
        if (start_shift) begin
          state_d    = SHIFT;
          cnt_d      = bus.cmd_amt;
          dir_left_d = (bus.cmd == C_CILN);
        end
      end
      SHIFT: begin
        cnt_d = cnt - AW'(1);
        if (cnt == AW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign shifting   = (state == SHIFT);
  assign shift_last = shifting && (cnt == AW'(1));
  assign shift_left = dir_left;
`else
  assign shifting   = 1'b0;
  assign shift_last = 1'b0;
  assign shift_left = 1'b0;
`endif

  always_comb begin
    ac_d   = ac_q;
    e_d    = e_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    if (shifting) begin
      ac_d   = bus.alu_result;
      e_d    = bus.alu_co;
      done_d = shift_last;
    end else if (bus.cmd_valid) begin
      case (bus.cmd)
        C_NOP: done_d = 1'b1;
        C_ADD: begin
          ac_d   = bus.alu_result;
          e_d    = bus.alu_co;
          ovf_d  = bus.alu_ovf;
          done_d = 1'b1;
        end
        C_AND, C_LDA, C_CMA: begin
          ac_d   = bus.alu_result;
          done_d = 1'b1;
        end
        C_CIR, C_CIL: begin
          ac_d   = bus.alu_result;
          e_d    = bus.alu_co;
          done_d = 1'b1;
        end
        C_CLA: begin
          ac_d   = '0;
          done_d = 1'b1;
        end
        C_CLE: begin
          e_d    = 1'b0;
          done_d = 1'b1;
        end
        C_CME: begin
          e_d    = ~e_q;
          done_d = 1'b1;
        end
        C_INC: begin
          ac_d   = ac_q + W'(1);
          done_d = 1'b1;
        end
        // A zero count completes at once; nonzero counts are handled by the SHIFT FSM.
        C_CIRN, C_CILN: done_d = MS_EN && (bus.cmd_amt == '0);
        default: done_d = 1'b0;
      endcase
    end
  end

  always_comb begin
    alu_op = OP_ADD;
    if (shifting) begin
      alu_op = shift_left ? OP_SHL : OP_SHR;
    end else if (bus.cmd_valid) begin
      case (bus.cmd)
        C_ADD:  alu_op = OP_ADD;
        C_AND:  alu_op = OP_AND;
        C_LDA:  alu_op = OP_TRAN;
        C_CMA:  alu_op = OP_COMP;
        C_CIR:  alu_op = OP_SHR;
        C_CIL:  alu_op = OP_SHL;
        C_CIRN: alu_op = MS_EN ? OP_SHR : OP_ADD;
        C_CILN: alu_op = MS_EN ? OP_SHL : OP_ADD;
        default: alu_op = OP_ADD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ac_q   <= '0;
      e_q    <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ac_q   <= ac_d;
      e_q    <= e_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  assign bus.ac     = ac_q;
  assign bus.e      = e_q;
  assign bus.ovf    = ovf_q;
  assign bus.z      = (ac_q == '0);
  assign bus.n      = ac_q[W-1];
  assign bus.busy   = shifting;
  assign bus.done   = done_q;
  assign bus.alu_op = alu_op;
endmodule

// File: tb/tb_acc_unit.sv
// Bench for acc_unit: behavioural ALU with bench-driven DR, directed plan steps, then random commands
// checked against a rotation/arithmetic reference model.
module tb_acc_unit;
  localparam int W    = 4;
  localparam int AW   = $clog2(W) + 1;
  localparam int N    = W + 1;
  localparam int MASK = (1 << W) - 1;

`ifdef ACC_UNIT_MULTISHIFT_EN
  localparam bit MS = 1'b1;
`else
  localparam bit MS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] dr;

  acc_unit_if #(.W(W)) bus ();

  acc_unit #(.W(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ALU: operands are AC/E from the DUT and DR from the bench.
  always_comb begin
    logic [W:0] sum;
    sum            = {1'b0, bus.ac} + {1'b0, dr};
    bus.alu_result = '0;
    bus.alu_co     = 1'b0;
    bus.alu_ovf    = 1'b0;
    case (bus.alu_op)
      3'd0: begin
        bus.alu_result = sum[W-1:0];
        bus.alu_co     = sum[W];
        bus.alu_ovf    = (bus.ac[W-1] == dr[W-1]) && (sum[W-1] != bus.ac[W-1]);
      end
      3'd1: bus.alu_result = bus.ac & dr;
      3'd2: bus.alu_result = dr;
      3'd3: bus.alu_result = ~bus.ac;
      3'd4: begin
        bus.alu_result = {bus.e, bus.ac[W-1:1]};
        bus.alu_co     = bus.ac[0];
      end
      3'd5: begin
        bus.alu_result = {bus.ac[W-2:0], bus.e};
        bus.alu_co     = bus.ac[W-1];
      end
      default: bus.alu_result = '0;
    endcase
  end

  int total = 0;
  int bad   = 0;
  int m_ac, m_e, m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
  endfunction

  // {E,AC} treated as one (W+1)-bit ring.
  function automatic int rot(input int v, input int r, input bit left);
    int rr;
    int msk;
    msk = (1 << N) - 1;
    rr  = r % N;
    if (rr == 0) return v;
    if (left) return ((v << rr) | (v >> (N - rr))) & msk;
    return ((v >> rr) | (v << (N - rr))) & msk;
  endfunction

  function automatic int exp_op(input int c);
    case (c)
      1: return 0;
      2: return 1;
      3: return 2;
      4: return 3;
      5: return 4;
      6: return 5;
      11: return MS ? 4 : 0;
      12: return MS ? 5 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic check_flags(input string tag, input int xac, input int xe, input int xovf);
    chk({tag, ".ac"}, 32'(bus.ac), 32'(xac));
    chk({tag, ".e"}, 32'(bus.e), 32'(xe));
    chk({tag, ".ovf"}, 32'(bus.ovf), 32'(xovf));
    chk({tag, ".z"}, 32'(bus.z), 32'(xac == 0));
    chk({tag, ".n"}, 32'(bus.n), 32'((xac >> (W - 1)) & 1));
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, ".done_low"}, 32'(bus.done), 32'd0);
    chk({tag, ".busy_low"}, 32'(bus.busy), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge where completion is visible.
  task automatic do_cmd(input string tag, input int c, input int amt, input int d, input bit poke);
    int  nac, ne, novf, k, v, s;
    bit  xdone;
    bit  left;
    nac   = m_ac;
    ne    = m_e;
    novf  = m_ovf;
    k     = 0;
    xdone = 1'b1;
    left  = (c == 12) || (c == 6);
    case (c)
      0: ;
      1: begin
        s    = m_ac + d;
        nac  = s & MASK;
        ne   = s >> W;
        s    = to_signed(m_ac) + to_signed(d);
        novf = (s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1))) ? 1 : 0;
      end
      2: nac = m_ac & d;
      3: nac = d;
      4: nac = ~m_ac & MASK;
      5, 6: begin
        v   = rot((m_e << W) | m_ac, 1, left);
        nac = v & MASK;
        ne  = v >> W;
      end
      7: nac = 0;
      8: ne = 0;
      9: ne = 1 - m_e;
      10: nac = (m_ac + 1) & MASK;
      11, 12: begin
        if (!MS) xdone = 1'b0;
        else if (amt > 0) k = amt;
      end
      default: xdone = 1'b0;
    endcase

    dr            = d[W-1:0];
    bus.cmd       = c[3:0];
    bus.cmd_amt   = amt[AW-1:0];
    bus.cmd_valid = 1'b1;
    #1;
    chk({tag, ".alu_op"}, 32'(bus.alu_op), 32'(exp_op(c)));
    @(negedge clk);
    bus.cmd_valid = 1'b0;

    if (k > 0) begin
      v = (m_e << W) | m_ac;
      for (int i = 1; i <= k; i++) begin
        chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
        chk({tag, ".done_in_busy"}, 32'(bus.done), 32'd0);
        chk({tag, ".shift_op"}, 32'(bus.alu_op), left ? 32'd5 : 32'd4);
        chk({tag, ".step_ac"}, 32'(bus.ac), 32'(rot(v, i - 1, left) & MASK));
        chk({tag, ".step_e"}, 32'(bus.e), 32'(rot(v, i - 1, left) >> W));
        if (poke && i < k) begin
          bus.cmd       = 4'd3;
          dr            = ~d[W-1:0];
          bus.cmd_valid = 1'b1;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
      end
      v   = rot(v, k, left);
      nac = v & MASK;
      ne  = v >> W;
    end

    chk({tag, ".done"}, 32'(bus.done), 32'(xdone));
    chk({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
    check_flags(tag, nac, ne, novf);
    m_ac  = nac;
    m_e   = ne;
    m_ovf = novf;
  endtask

  initial begin
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd       = '0;
    bus.cmd_amt   = '0;
    dr            = '0;
    m_ac          = 0;
    m_e           = 0;
    m_ovf         = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_flags("reset", 0, 0, 0);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.alu_op", 32'(bus.alu_op), 32'd0);
    reset = 1'b0;

    do_cmd("lda_a", 3, 0, 'hA, 1'b0);
    do_cmd("cma", 4, 0, 0, 1'b0);
    idle_chk("after_cma");

    do_cmd("lda_7", 3, 0, 7, 1'b0);
    do_cmd("add_1", 1, 0, 1, 1'b0);
    do_cmd("add_8", 1, 0, 8, 1'b0);
    idle_chk("after_add");

    do_cmd("lda_1", 3, 0, 1, 1'b0);
    do_cmd("cirn_3", 11, 3, 0, 1'b1);
    idle_chk("after_cirn");

    do_cmd("lda_b", 3, 0, 'hB, 1'b0);
    do_cmd("cle", 8, 0, 0, 1'b0);
    do_cmd("ciln_5", 12, 5, 0, 1'b1);
    idle_chk("after_ciln");

    // Reset after the second shift of a CIL_N 5 aborts with no completion pulse.
    dr            = '0;
    bus.cmd       = 4'd12;
    bus.cmd_amt   = AW'(5);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort.busy_before", 32'(bus.busy), 32'(MS));
    chk("abort.done_before", 32'(bus.done), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ac  = 0;
    m_e   = 0;
    m_ovf = 0;
    check_flags("abort", 0, 0, 0);
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.done", 32'(bus.done), 32'd0);
    idle_chk("abort_next");

    do_cmd("lda_6", 3, 0, 6, 1'b0);
    do_cmd("cirn_0", 11, 0, 0, 1'b0);
    do_cmd("illegal_13", 13, 0, 0, 1'b0);
    idle_chk("after_illegal");
    do_cmd("lda_f", 3, 0, 'hF, 1'b0);
    do_cmd("inc_wrap", 10, 0, 0, 1'b0);
    do_cmd("cme", 9, 0, 0, 1'b0);
    do_cmd("cla", 7, 0, 0, 1'b0);

    for (int r = 0; r < 150; r++) begin
      do_cmd("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, (1 << AW) - 1)),
             int'($urandom_range(0, MASK)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_chk("rand_idle");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
